// File: rtl/float_pkg.sv
// -----------------------------------------------------------------------------
// float_pkg
//
// Shared types and constants for the G.726 float <-> linear conversion blocks.
//   float11_t   : 11-bit floating-point operand {sign, 4-bit exponent, 6-bit mantissa}
//   dq15_t      : 15-bit sign-magnitude linear value {sign, 14-bit magnitude}
//   MAX_EXP     : largest legal exponent
//   MANT_ZERO   : mantissa used to encode a zero magnitude (exp=0, mant=32)
//   f2d_state_t : control states of the iterative float-to-linear shifter
// -----------------------------------------------------------------------------
package float_pkg;

  typedef struct packed {
    logic       sgn;
    logic [3:0] exp;
    logic [5:0] mant;
  } float11_t;

  typedef struct packed {
    logic        sgn;
    logic [13:0] mag;
  } dq15_t;

  localparam int         MAX_EXP   = 14;
  localparam logic [5:0] MANT_ZERO = 6'd32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } f2d_state_t;

endpackage : float_pkg

// File: rtl/float_to_dq.sv
// -----------------------------------------------------------------------------
// float_to_dq
//
// Re-expands an 11-bit G.726 floating-point operand into a 15-bit
// sign-magnitude linear value: magnitude = (mant << exp) >> 6, sign passed
// through unchanged (negative zero included). The left shift is done one bit
// per clock in a 20-bit accumulator; one operand is in flight at a time.
//
// Ports
//   clk                 system clock, rising edge
//   reset               synchronous, active-high reset
//   in_valid / in_ready input handshake; in_dq0 = {sgn, exp[3:0], mant[5:0]}
//   out_valid/ out_ready output handshake; out_dq = {sgn, mag[13:0]}
//   out_err             (FLOAT2DQ_CHECK_EN only) operand error, valid with out_valid
//   scan_in0..4, scan_enable, test_mode   DFT inputs, functionally unused
//   scan_out0..4        DFT outputs, tied low until scan insertion
//
// Configuration macro
//   FLOAT2DQ_CHECK_EN : adds out_err. Unnormalised mantissas (mant[5]==0)
//                       flag an error and return magnitude 0; exponents above
//                       MAX_EXP flag an error and saturate to 14'h3FFF.
//                       Without it, large exponents are clamped to MAX_EXP
//                       and unnormalised mantissas are converted as-is.
// -----------------------------------------------------------------------------
module float_to_dq
  import float_pkg::*;
#(
  parameter int MAX_EXP = float_pkg::MAX_EXP,
  parameter int ACC_W   = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] in_dq0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] out_dq,
`ifdef FLOAT2DQ_CHECK_EN
  output logic        out_err,
`endif
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  input  logic        scan_enable,
  input  logic        test_mode,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4
);

  localparam logic [3:0] MAX_EXP_4 = 4'(MAX_EXP);

  // DFT pins are stitched at scan insertion; functionally they do nothing.
  logic unused_dft;
  assign unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                        scan_enable, test_mode};
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  float11_t in_f;
  assign in_f = float11_t'(in_dq0);

  // State and datapath registers
  f2d_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  dq15_t            out_dq_q, out_dq_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
`ifdef FLOAT2DQ_CHECK_EN
  logic             ovf_q, ovf_d;
  logic             unnorm_q, unnorm_d;
  logic             out_err_q, out_err_d;
`endif

  // Combinational helpers
  logic [ACC_W-1:0] acc_load;
  logic [ACC_W-1:0] acc_shl;
  logic [3:0]       exp_clamped;
  logic             accept;

  // Finishing path: selected source of the result written into out_dq
  logic             fin;
  logic [ACC_W-1:0] fin_acc;
  logic             fin_sgn;
  logic [13:0]      fin_mag;
`ifdef FLOAT2DQ_CHECK_EN
  logic             fin_ovf;
  logic             fin_unnorm;
`endif

  assign acc_load    = {{(ACC_W-6){1'b0}}, in_f.mant};
  assign acc_shl     = acc_q << 1;
  assign exp_clamped = (in_f.exp > MAX_EXP_4) ? MAX_EXP_4 : in_f.exp;
  assign accept      = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sgn_d       = sgn_q;
    out_dq_d    = out_dq_q;
`ifdef FLOAT2DQ_CHECK_EN
    ovf_d       = ovf_q;
    unnorm_d    = unnorm_q;
    out_err_d   = out_err_q;
    fin_ovf     = ovf_q;
    fin_unnorm  = unnorm_q;
`endif
    fin         = 1'b0;
    fin_acc     = acc_shl;
    fin_sgn     = sgn_q;
    fin_mag     = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          sgn_d    = in_f.sgn;
          acc_d    = acc_load;
          cnt_d    = exp_clamped;
`ifdef FLOAT2DQ_CHECK_EN
          ovf_d    = (in_f.exp > MAX_EXP_4);
          unnorm_d = ~in_f.mant[5];
`endif
          if (in_f.exp == 4'd0) begin
            // Nothing to shift: the result is ready on the accept edge.
            fin        = 1'b1;
            fin_acc    = acc_load;
            fin_sgn    = in_f.sgn;
`ifdef FLOAT2DQ_CHECK_EN
            fin_ovf    = 1'b0;
            fin_unnorm = ~in_f.mant[5];
`endif
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        acc_d = acc_shl;
        cnt_d = cnt_q - 4'd1;
        // Final shift and the move to DONE share one edge.
        if (cnt_q == 4'd1) begin
          fin = 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (fin) begin
      state_d = DONE;
      fin_mag = fin_acc[6 +: 14];
`ifdef FLOAT2DQ_CHECK_EN
      if (fin_ovf) begin
        fin_mag = 14'h3FFF;
      end else if (fin_unnorm) begin
        fin_mag = 14'h0000;
      end
      out_err_d = fin_ovf | fin_unnorm;
`endif
      out_dq_d.sgn = fin_sgn;
      out_dq_d.mag = fin_mag;
    end

    // Handshake flags are a decode of the next state, so both are registered
    // and in_ready has no combinational dependence on out_ready.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      out_dq_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef FLOAT2DQ_CHECK_EN
      ovf_q       <= 1'b0;
      unnorm_q    <= 1'b0;
      out_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sgn_q       <= sgn_d;
      out_dq_q    <= out_dq_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef FLOAT2DQ_CHECK_EN
      ovf_q       <= ovf_d;
      unnorm_q    <= unnorm_d;
      out_err_q   <= out_err_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_dq    = out_dq_q;
`ifdef FLOAT2DQ_CHECK_EN
  assign out_err   = out_err_q;
`endif

endmodule : float_to_dq

// File: tb/tb_float_to_dq.sv
// -----------------------------------------------------------------------------
// tb_float_to_dq
//
// Directed checks of float_to_dq: reset values, a table of operands with
// hand-computed results and latencies, a FLOATA round-trip sweep, output
// backpressure, and reset in the middle of a shift.
// -----------------------------------------------------------------------------
module tb_float_to_dq;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_dq0;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_dq;
`ifdef FLOAT2DQ_CHECK_EN
  logic        out_err;
`endif
  logic [4:0]  scan_out;

  int n_cmp;
  int n_bad;

  float_to_dq dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dq0      (in_dq0),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_dq      (out_dq),
`ifdef FLOAT2DQ_CHECK_EN
    .out_err     (out_err),
`endif
    .scan_in0    (1'b0),
    .scan_in1    (1'b0),
    .scan_in2    (1'b0),
    .scan_in3    (1'b0),
    .scan_in4    (1'b0),
    .scan_enable (1'b0),
    .test_mode   (1'b0),
    .scan_out0   (scan_out[0]),
    .scan_out1   (scan_out[1]),
    .scan_out2   (scan_out[2]),
    .scan_out3   (scan_out[3]),
    .scan_out4   (scan_out[4])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then presents op for exactly one accept edge.
  task automatic send(input logic [10:0] op);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_dq0   = op;
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  typedef struct {
    logic [10:0] op;
    logic [14:0] exp_dq;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  // FLOATA reference: magnitude -> {exp, mant}
  function automatic logic [9:0] floata(input logic [13:0] m);
    int e;
    logic [19:0] w;
    e = 0;
    for (int i = 0; i < 14; i++) if (m[i]) e = i + 1;
    if (e == 0) return {4'd0, 6'd32};
    w = {6'd0, m} << 6;
    w = w >> e;
    return {4'(e), w[5:0]};
  endfunction

  // Keeps the six most significant bits of m, truncating the rest.
  function automatic logic [13:0] trunc6(input logic [13:0] m);
    int e;
    logic [13:0] mask;
    e = 0;
    for (int i = 0; i < 14; i++) if (m[i]) e = i + 1;
    if (e <= 6) return m;
    mask = 14'h3FFF << (e - 6);
    return m & mask;
  endfunction

  initial begin
    int lat;
    int seen;
    logic [13:0] m;
    logic [9:0]  f;

    n_cmp     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_dq0    = '0;
    out_ready = 1'b0;

    vecs[0] = '{ {1'b0, 4'd0,  6'd32}, 15'h0000, 1,  1'b0 };
    vecs[1] = '{ {1'b1, 4'd0,  6'd32}, 15'h4000, 1,  1'b0 };
    vecs[2] = '{ {1'b0, 4'd7,  6'd50}, 15'd100,  8,  1'b0 };
    vecs[3] = '{ {1'b0, 4'd1,  6'd32}, 15'd1,    2,  1'b0 };
    vecs[4] = '{ {1'b1, 4'd14, 6'd63}, {1'b1, 14'd16128}, 15, 1'b0 };
`ifdef FLOAT2DQ_CHECK_EN
    vecs[5] = '{ {1'b0, 4'd15, 6'd40}, 15'h3FFF, 15, 1'b1 };
    vecs[6] = '{ {1'b0, 4'd3,  6'd12}, 15'h0000, 4,  1'b1 };
    vecs[9] = '{ {1'b1, 4'd0,  6'd0},  15'h4000, 1,  1'b1 };
`else
    vecs[5] = '{ {1'b0, 4'd15, 6'd40}, 15'd10240, 15, 1'b0 };
    vecs[6] = '{ {1'b0, 4'd3,  6'd12}, 15'd1,     4,  1'b0 };
    vecs[9] = '{ {1'b1, 4'd0,  6'd0},  15'h4000,  1,  1'b0 };
`endif
    vecs[7] = '{ {1'b1, 4'd5,  6'd33}, {1'b1, 14'd16}, 6,  1'b0 };
    vecs[8] = '{ {1'b0, 4'd10, 6'd45}, 15'd720,  11, 1'b0 };

    // Reset values
    repeat (3) tick();
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_dq",    32'(out_dq),    32'd0);
    check("rst_scan_out",  32'(scan_out),  32'd0);
    reset = 1'b0;
    tick();

    // Table of directed operands
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].op);
      wait_result(lat);
      check($sformatf("v%0d_latency", i), 32'(lat),    32'(vecs[i].exp_lat));
      check($sformatf("v%0d_out_dq", i),  32'(out_dq), 32'(vecs[i].exp_dq));
`ifdef FLOAT2DQ_CHECK_EN
      check($sformatf("v%0d_out_err", i), 32'(out_err), 32'(vecs[i].exp_err));
`endif
      $display("vec %0d: op=0x%03h out_dq=0x%04h latency=%0d", i, vecs[i].op, out_dq, lat);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check($sformatf("v%0d_rel_valid", i), 32'(out_valid), 32'd0);
      check($sformatf("v%0d_rel_ready", i), 32'(in_ready),  32'd1);
    end

    // FLOATA round trip over random magnitudes
    for (int i = 0; i < 8; i++) begin
      m = 14'($urandom_range(0, 16383));
      f = floata(m);
      send({1'b0, f});
      wait_result(lat);
      check($sformatf("rt%0d_mag", i), 32'(out_dq), 32'({1'b0, trunc6(m)}));
`ifdef FLOAT2DQ_CHECK_EN
      check($sformatf("rt%0d_err", i), 32'(out_err), 32'd0);
`endif
      $display("roundtrip %0d: mag=%0d float=0x%03h out_dq=%0d", i, m, f, out_dq);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    // Backpressure: result held, new operand refused
    send({1'b0, 4'd7, 6'd50});
    wait_result(lat);
    in_valid = 1'b1;
    in_dq0   = {1'b1, 4'd2, 6'd40};
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp%0d_out_dq", c),    32'(out_dq),    32'd100);
      check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_in_ready", c),  32'(in_ready),  32'd0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_rel_in_ready",  32'(in_ready),  32'd1);
    check("bp_rel_out_valid", 32'(out_valid), 32'd0);
    repeat (3) tick();
    check("bp_not_consumed", 32'(out_valid), 32'd0);
    $display("backpressure: held 5 cycles, released");

    // Reset in the third SHIFT cycle
    send({1'b0, 4'd10, 6'd45});
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_dq",    32'(out_dq),    32'd0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (out_valid) seen++;
      tick();
    end
    check("mid_rst_dropped", 32'(seen), 32'd0);
    $display("mid-shift reset: operand dropped");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_float_to_dq

// File: doc/float_to_dq.md
# float_to_dq

Converts G.726 11-bit floating-point operands (sign, 4-bit exponent, 6-bit mantissa) back to 15-bit sign-magnitude linear values. It is the inverse of the FLOATA magnitude-to-float conversion. It sits in the ADPCM datapath wherever a stored float operand must be re-expanded to linear form, for example in reconstructed-signal checks and predictor debug readback. It uses an iterative shifter behind a valid/ready handshake on both sides.

## Interface
Parameters:
- MAX_EXP, 14: largest legal exponent.
- ACC_W, 20: shift accumulator width; covers 63 << 14.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_dq0 holds a valid operand.
- in_ready  output  1  block can accept an operand.
- in_dq0  input  11  bit [10] sign, bits [9:6] exponent, bits [5:0] mantissa.
- out_valid  output  1  out_dq holds a result.
- out_ready  input  1  downstream accepts the result.
- out_dq  output  15  bit [14] sign, bits [13:0] magnitude.
- scan_in0..4, scan_enable, test_mode  input  1 each  DFT; not used functionally.
- scan_out0..4  output  1 each  DFT; tied 0 in RTL and stitched at scan insertion.

## Operation
- Function: magnitude = (mant << exp) >> 6, which is acc[19:6] of the 20-bit accumulator. Sign passes through unchanged, including negative zero.
- Zero needs no special case: exp=0, mant=32 gives magnitude 0.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=0; acc <<= 1 and cnt -= 1 each cycle.
  - DONE: out_valid=1; out_dq is stable until accepted.
- Transitions:
  - IDLE to SHIFT on in_valid & in_ready when exp != 0. Capture sign, acc = {14'b0, mant}, cnt = exp.
  - IDLE to DONE on accept when exp == 0.
  - SHIFT to DONE when cnt == 1, in the same edge as the final shift.
  - DONE to IDLE on out_ready.
- Exponent above MAX_EXP is clamped to MAX_EXP before loading cnt.
- One operand in flight at a time. in_ready is low in SHIFT and DONE, and the block does not accept in the same cycle that a result is released.
- Reset in any state returns to IDLE, clears acc, cnt and out_dq, and drops the in-flight operand.

## Timing
- Reset values: in_ready=1, out_valid=0, out_dq=0, all scan_out=0.
- Latency counts from the accept edge to out_valid high: exp=0 gives 1 cycle; exp=k gives k+1 cycles.
- Worst-case throughput: one operand per MAX_EXP+2 cycles plus any out_ready stall.
- in_ready is a registered state decode, with no combinational path from out_ready.
- out_dq and out_valid are registered.
- With out_ready held low, out_valid and out_dq hold indefinitely.
- When in_valid is asserted during SHIFT or DONE, nothing is accepted and the upstream must hold the operand.

## Configuration
- FLOAT2DQ_CHECK_EN, when defined:
  - Adds output port out_err (1 bit, reset 0). It is valid with out_valid.
  - out_err=1 when mant[5]==0, which is an unnormalised operand.
  - out_err=1 when exp > MAX_EXP; in this case the magnitude saturates to 14'h3FFF instead of clamping.
- When not defined:
  - There is no out_err port.
  - Exponents above MAX_EXP are clamped silently.
  - Unnormalised mantissas are converted arithmetically with no indication.

## Structure
- Shared package float_pkg holds:
  - typedef struct packed {logic sgn; logic [3:0] exp; logic [5:0] mant;} float11_t
  - typedef struct packed {logic sgn; logic [13:0] mag;} dq15_t
  - constants MAX_EXP and MANT_ZERO=6'd32
  - enum f2d_state_t {IDLE, SHIFT, DONE}
- Single module, with no sub-module: the shifter is a few lines of state-register logic.

## Test plan
- in_dq0 = {0,4'd0,6'd32} → out_dq=15'h0000 with out_valid 1 cycle after accept; {1,0,32} → 15'h4000.
- {0,4'd7,6'd50} → magnitude 100, out_valid exactly 8 cycles after accept. {0,4'd1,6'd32} → magnitude 1.
- {1,4'd14,6'd63} → out_dq = {1, 14'd16128} after 15 cycles. A random 14-bit magnitude sweep through a FLOATA reference model returns the original magnitude truncated to 6 significant bits.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_dq stable, in_ready=0 throughout, and a new in_valid is not consumed. Release → IDLE the next cycle.
- Reset asserted mid-SHIFT (exp=10, third cycle) → next cycle in_ready=1, out_valid=0, out_dq=0, and the operand is not emitted.
- FLOAT2DQ_CHECK_EN, exponent overflow: {0,4'd15,6'd40} → out_err=1, magnitude 14'h3FFF.
- FLOAT2DQ_CHECK_EN, unnormalised: {0,4'd3,6'd12} → out_err=1, magnitude 0.
- Without FLOAT2DQ_CHECK_EN: {0,15,40} → magnitude (40 << 14) >> 6 = 10240.
